// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Round-robin arbiter sharing one data-memory port between NUM_CONSUMERS LSUs.
// Each LSU has a private valid/ready read channel and write channel. One memory
// transaction is in flight at a time; its result is relayed back to the owning
// LSU, whose ready stays high until that LSU drops its valid.
//
// Ports (consumer i occupies bit i, or slice [i*W +: W], of each vector):
//   clk                     rising-edge clock
//   reset                   synchronous, active-high
//   consumer_read_valid     per-LSU read request
//   consumer_read_address   per-LSU read address
//   consumer_read_ready     per-LSU read-done strobe (registered)
//   consumer_read_data      per-LSU last returned read data (registered)
//   consumer_write_valid    per-LSU write request
//   consumer_write_address  per-LSU write address
//   consumer_write_data     per-LSU write data
//   consumer_write_ready    per-LSU write-done strobe (registered)
//   mem_read_valid/_address memory read request (registered)
//   mem_read_ready/_data    memory read completion and data
//   mem_write_valid/_address/_data  memory write request (registered)
//   mem_write_ready         memory write completion
module mem_arbiter #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,

    input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,

    input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,

    output logic                                 mem_read_valid,
    output logic [ADDR_BITS-1:0]                 mem_read_address,
    input  logic                                 mem_read_ready,
    input  logic [DATA_BITS-1:0]                 mem_read_data,

    output logic                                 mem_write_valid,
    output logic [ADDR_BITS-1:0]                 mem_write_address,
    output logic [DATA_BITS-1:0]                 mem_write_data,
    input  logic                                 mem_write_ready
);

    localparam int OWNER_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam logic [OWNER_BITS-1:0] LAST_OWNER = OWNER_BITS'(NUM_CONSUMERS - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ_WAITING,
        WRITE_WAITING,
        READ_RELAY,
        WRITE_RELAY
    } state_t;

    state_t                state;
    logic [OWNER_BITS-1:0] ptr;
    logic [OWNER_BITS-1:0] owner;
    logic [OWNER_BITS-1:0] next_ptr;

    // Unpacked per-consumer views of the packed buses.
    logic [ADDR_BITS-1:0] rd_addr   [NUM_CONSUMERS];
    logic [ADDR_BITS-1:0] wr_addr   [NUM_CONSUMERS];
    logic [DATA_BITS-1:0] wr_data   [NUM_CONSUMERS];
    logic [DATA_BITS-1:0] rd_data_q [NUM_CONSUMERS];

    for (genvar i = 0; i < NUM_CONSUMERS; i++) begin : g_unpack
        assign rd_addr[i] = consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
        assign wr_addr[i] = consumer_write_address[i*ADDR_BITS +: ADDR_BITS];
        assign wr_data[i] = consumer_write_data[i*DATA_BITS +: DATA_BITS];
        assign consumer_read_data[i*DATA_BITS +: DATA_BITS] = rd_data_q[i];
    end

    // Round-robin search: first requester at or after ptr, wrapping.
    logic                  grant_found;
    logic                  grant_is_read;
    logic [OWNER_BITS-1:0] grant_idx;
    logic [OWNER_BITS-1:0] scan_idx;
    int                    scan_sum;

    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        grant_found   = 1'b0;
        grant_is_read = 1'b0;
        grant_idx     = '0;
        scan_idx      = '0;
        scan_sum      = 0;
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
            scan_sum = int'(ptr) + k;
            if (scan_sum >= NUM_CONSUMERS) begin
                scan_sum = scan_sum - NUM_CONSUMERS;
            end
            scan_idx = OWNER_BITS'(scan_sum);
            if (!grant_found &&
                (consumer_read_valid[scan_idx] || consumer_write_valid[scan_idx])) begin
                grant_found   = 1'b1;
                grant_idx     = scan_idx;
                // A consumer asking for both is served its read first.
                grant_is_read = consumer_read_valid[scan_idx];
            end
        end
    end

    assign next_ptr = (owner == LAST_OWNER) ? '0 : owner + 1'b1;

    // NOTE: all state and outputs are updated with non-blocking assignments so
    // every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= IDLE;
            ptr                  <= '0;
            owner                <= '0;
            mem_read_valid       <= 1'b0;
            mem_read_address     <= '0;
            mem_write_valid      <= 1'b0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            // NOTE: the per-consumer read-data registers are outputs that must
            // read 0 after reset, so this small array is reset explicitly.
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
                rd_data_q[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        owner <= grant_idx;
                        if (grant_is_read) begin
                            mem_read_valid   <= 1'b1;
                            mem_read_address <= rd_addr[grant_idx];
                            state            <= READ_WAITING;
                        end else begin
                            mem_write_valid   <= 1'b1;
                            mem_write_address <= wr_addr[grant_idx];
                            mem_write_data    <= wr_data[grant_idx];
                            state             <= WRITE_WAITING;
                        end
                    end
                end

                // The owner may drop valid while waiting; the transaction
                // still completes and the ready pulse is still relayed.
                READ_WAITING: begin
                    if (mem_read_ready) begin
                        mem_read_valid             <= 1'b0;
                        rd_data_q[owner]           <= mem_read_data;
                        consumer_read_ready[owner] <= 1'b1;
                        state                      <= READ_RELAY;
                    end
                end

                WRITE_WAITING: begin
                    if (mem_write_ready) begin
                        mem_write_valid             <= 1'b0;
                        consumer_write_ready[owner] <= 1'b1;
                        state                       <= WRITE_RELAY;
                    end
                end

                READ_RELAY: begin
                    if (!consumer_read_valid[owner]) begin
                        consumer_read_ready <= '0;
                        ptr                 <= next_ptr;
                        state               <= IDLE;
                    end
                end

                WRITE_RELAY: begin
                    if (!consumer_write_valid[owner]) begin
                        consumer_write_ready <= '0;
                        ptr                  <= next_ptr;
                        state                <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares one external data-memory port between NUM_CONSUMERS per-thread LSUs. It sits between the LSUs of a core and the data-memory interface. Each LSU sees a private valid/ready read and write channel. The arbiter serializes their requests onto the single memory port, one transaction in flight at a time, and relays the response back to the owning LSU.

## Interface
Parameters:
- NUM_CONSUMERS, default 4: number of LSUs served; must be at least 1.
- ADDR_BITS, default 8: memory address width.
- DATA_BITS, default 8: memory data width.

Ports (vectors are packed; consumer i occupies bit i, or slice [i*W +: W]):
- clk, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high.
- consumer_read_valid, in, NUM_CONSUMERS: per-LSU read request.
- consumer_read_address, in, NUM_CONSUMERS*ADDR_BITS: read addresses.
- consumer_read_ready, out, NUM_CONSUMERS: read-done strobe per LSU.
- consumer_read_data, out, NUM_CONSUMERS*DATA_BITS: returned read data per LSU.
- consumer_write_valid, in, NUM_CONSUMERS: per-LSU write request.
- consumer_write_address, in, NUM_CONSUMERS*ADDR_BITS: write addresses.
- consumer_write_data, in, NUM_CONSUMERS*DATA_BITS: write data.
- consumer_write_ready, out, NUM_CONSUMERS: write-done strobe per LSU.
- mem_read_valid, out, 1: memory read request.
- mem_read_address, out, ADDR_BITS: memory read address.
- mem_read_ready, in, 1: memory read completion.
- mem_read_data, in, DATA_BITS: memory read data, valid when mem_read_ready is high.
- mem_write_valid, out, 1: memory write request.
- mem_write_address, out, ADDR_BITS: memory write address.
- mem_write_data, out, DATA_BITS: memory write data.
- mem_write_ready, in, 1: memory write completion.

## Operation
- All outputs are registered. On reset, every output is 0, the state is IDLE, the grant pointer is 0 and the owner is 0.
- States:
  - IDLE: search for a request.
  - READ_WAITING: read in flight on the memory port.
  - WRITE_WAITING: write in flight on the memory port.
  - READ_RELAY: holding consumer_read_ready high.
  - WRITE_RELAY: holding consumer_write_ready high.
- IDLE:
  - Scan consumers in order ptr, ptr+1, …, wrapping modulo NUM_CONSUMERS.
  - The first consumer i with read_valid or write_valid set becomes the owner.
  - Read: mem_read_valid←1, mem_read_address←its address, go to READ_WAITING.
  - Write: mem_write_valid←1, mem_write_address and mem_write_data←its values, go to WRITE_WAITING.
  - If consumer i asserts both read_valid and write_valid, the read is served first. The write stays pending.
- READ_WAITING:
  - Stay until mem_read_ready is 1.
  - On that cycle: mem_read_valid←0, consumer_read_data[owner]←mem_read_data, consumer_read_ready[owner]←1, go to READ_RELAY.
- WRITE_WAITING:
  - Stay until mem_write_ready is 1.
  - On that cycle: mem_write_valid←0, consumer_write_ready[owner]←1, go to WRITE_RELAY.
- READ_RELAY / WRITE_RELAY:
  - Hold the owner's ready high while the owner's matching valid is still 1.
  - When the owner's valid samples 0: ready←0, ptr←(owner+1) mod NUM_CONSUMERS, go to IDLE.
- consumer_read_data[i] holds its last value until overwritten by a later read for consumer i.
- Only the owner's ready bit may be 1, and only in the matching RELAY state. All other ready bits are 0.
- The owner's address and data are latched at grant. Changes to the consumer inputs after grant do not affect the memory port.
- If the owner drops valid during a WAITING state, the transaction still completes and is relayed normally.
- mem_read_valid and mem_write_valid are never high together.

## Timing
- Edge E0: the request is sampled in IDLE. After E0, mem_*_valid is 1.
- Edge E1 (earliest): memory ready is sampled. After E1, consumer ready is 1 and read data is valid.
- Edge E2: the LSU sees ready and drops valid.
- Edge E3: the arbiter sees valid low. After E3, ready is 0 and the state is IDLE.
- The next grant can be made at E4. Minimum transaction occupancy is therefore 4 cycles plus memory wait cycles.
- Memory wait is unbounded; the arbiter waits indefinitely.
- Round-robin fairness: a continuously requesting consumer waits for at most NUM_CONSUMERS−1 other transactions.
- Reset mid-transaction: all outputs clear on the next edge and the in-flight memory transaction is abandoned. mem_*_valid drops even if memory has not responded.

## Test plan
- Single read: consumer 2 reads address 0x10, memory returns 0xA5 with ready on its first valid cycle. Required: mem_read_address=0x10 after E0, consumer_read_ready=0b0100 with data slice 2 = 0xA5 after E1, ready cleared one cycle after valid drops.
- Round-robin: all 4 consumers request reads continuously. Required: grants in order 0,1,2,3,0. In every transaction, mem_read_address matches the owner's address.
- Mixed read and write: consumer 1 writes 0x3C to 0x20 while consumer 0 reads 0x20, memory is a 256-byte model. Required: consumer 0 is served first (ptr=0). The write then lands, mem_write_data=0x3C, and a subsequent read of 0x20 returns 0x3C.
- Memory stall: mem_read_ready is held low for 10 cycles. Required: mem_read_valid stays 1 and the address is stable throughout. Consumer ready rises only after the cycle ready is sampled high.
- Reset mid-transaction: assert reset during WRITE_WAITING. Required: all outputs 0 and state IDLE after the edge. A fresh request from consumer 3 after reset is granted first (ptr=0 scan, no other requesters).
- Same consumer issues read and write together: required order is read, then write, both relayed. The two memory valids never overlap.
